blink_meter: RTL and testbench
==============================

# blink_meter

Memory-mapped slot core that measures the half-period of up to four slowly toggling input lines, such as LED drive signals or switch lines, in millisecond units. The processor reads the results over the standard slot bus. It is the read-side counterpart of the LED blink core: `led_blink` generates blink intervals from register writes, and `blink_meter` recovers those intervals from the pins. It sits in an MMIO slot alongside the other I/O cores, and its `din` pins can be looped back from `led_blink.dout` for self-test.

## Interface
Parameters:
- `CLKS_PER_MS`, default 100_000: clock cycles per 1 ms tick (100 MHz system clock).
- `CNT_W`, default 16: width of each half-period counter and result register.

Ports:
- `clk`, input, 1: system clock. This is the only clock in the block.
- `reset`, input, 1: synchronous, active-high reset.
- `cs`, input, 1: slot select.
- `read`, input, 1: read strobe. No side effects on read.
- `write`, input, 1: write strobe. A write takes effect only when `cs && write`.
- `addr`, input, 5: register address.
- `wr_data`, input, 32: write data.
- `rd_data`, output, 32: read data. Combinational from `addr`.
- `din`, input, 4: asynchronous lines to be measured.

## Operation
- Register map on read (unused bits read as 0; addresses 6–31 read as 0):
  - Addresses 0–3: `period[i]`, zero-extended to 32 bits.
  - Address 4: status word. Bits [3:0] are `valid[3:0]`; bits [7:4] are the synchronized `din` levels.
  - Address 5: control word. Bits [3:0] are `en[3:0]`.
- Register map on write:
  - Address 4: write-1-to-clear of `valid[i]` using `wr_data[3:0]`.
  - Address 5: sets `en[3:0] <= wr_data[3:0]`.
  - Writes to any other address are ignored.
- Input path, per channel:
  - Two-flop synchronizer, then an edge register.
  - `edge[i] = sync[i] ^ prev[i]`. Both rising and falling edges count.
- Millisecond prescaler:
  - One shared, free-running counter from 0 to `CLKS_PER_MS-1`.
  - `tick` asserts for one cycle when the counter equals `CLKS_PER_MS-1`.
  - The prescaler is unaffected by `en`.
- Per-channel state machine with states DISARMED and ARMED:
  - On reset, or whenever `en[i]=0`, the channel is held in DISARMED with `cnt[i]=0`.
  - DISARMED, `en[i]=1` and `edge[i]`: `cnt[i] <= 0`, go to ARMED. `period[i]` and `valid[i]` are not touched, because the first edge only starts timing.
  - ARMED, `edge[i]`: `period[i] <= cnt[i]`, `valid[i] <= 1`, `cnt[i] <= 0`. The channel stays ARMED.
  - ARMED, `tick` with no edge: `cnt[i] <= cnt[i]+1`, saturating at 2^`CNT_W`-1 with no wrap.
  - ARMED and `en[i]` falls: go to DISARMED. `period[i]` and `valid[i]` are retained.
- Simultaneous events:
  - Edge and tick in the same cycle: the edge wins. The captured value is the pre-increment `cnt[i]`, and the counter restarts at 0.
  - Edge capture and a W1C write of `valid[i]` in the same cycle: the set wins, so `valid[i]=1`.
  - Channels are fully independent.
- A saturated capture reads as 0xFFFF with `valid=1`. Software treats this as "slower than measurable".

## Timing
- Reset values: `rd_data` follows `addr` with all registers at 0, so it reads 0 everywhere. Also on reset:
  - `en=0`, `valid=0`, `period=0`, `cnt=0`, prescaler=0.
  - Synchronizer and edge flops are 0, and the FSMs are DISARMED.
- Reset in the middle of a measurement discards all state immediately, on the next clock edge.
- Pin-to-capture latency: a `din` transition appears in `period`/`valid` 3 clocks after the first sampling edge (2 synchronizer stages plus 1 edge register), and is readable on the following cycle.
- Resolution: the result counts whole ticks between edges, so it is accurate to −1/+0 ms relative to the true half-period.
- Register writes take effect on the clock edge where `cs && write` is high. `rd_data` reflects the new value in the next cycle.

## Test plan
For simulation, `CLKS_PER_MS=10`.
- **Reset values:** assert `reset` for 2 clocks, then read addresses 0–5 → every read returns 0x0000_0000.
- **Basic measurement:** write address 5 = 0x1, then toggle `din[0]` every 50 clocks → after the second edge, `period[0]=5` and status bit 0 = 1. After the first edge only, `valid[0]=0`.
- **Independent channels:** enable all channels with half-periods of 20, 30, 70 and 100 clocks on `din[3:0]` → `period` = 2, 3, 7, 10 respectively, and status reads 0x?F, where the upper nibble is the current levels.
- **Saturation:** with `CNT_W=4` and `en[1]=1`, hold `din[1]` for 300 clocks between edges → `period[1]=15`.
- **W1C and race:** write address 4 = 0x1 and confirm `valid[0]=0`. Then align a W1C write with the capture cycle → `valid[0]` reads 1.
- **Disable and reset mid-run:** clearing `en[0]` mid-measurement retains `period[0]`, and the next edge after re-enabling does not update it. Asserting `reset` mid-count → all registers read 0, and the first edge after reset does not set `valid`.

Source files
------------

// File: rtl/blink_meter.sv
// blink_meter: measures the half-period of four slow input lines in 1 ms ticks
// and exposes the results, valid flags and enables on the slot bus.
//
// Per-channel state | meaning
// DISARMED          | channel idle or disabled; counter held at 0, waiting for a starting edge
// ARMED             | timing between edges; each edge captures the count and restarts it

module blink_meter #(
    parameter int CLKS_PER_MS = 100_000,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [3:0]  din
);

    localparam int PS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLKS_PER_MS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } state_t;

    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      prev_q, prev_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [3:0]      en_q, en_d;
    logic [3:0]      valid_q, valid_d;
    state_t          state_q  [4];
    state_t          state_d  [4];
    logic [CNT_W-1:0] cnt_q    [4];
    logic [CNT_W-1:0] cnt_d    [4];
    logic [CNT_W-1:0] period_q [4];
    logic [CNT_W-1:0] period_d [4];

    logic       tick;
    logic       wr_en;
    logic [3:0] edge_det;
    logic [3:0] clr;
    logic       unused_ok;

    // read strobes have no side effects, and only the low nibble of write data matters
    assign unused_ok = ^{read, wr_data[31:4]};

    assign wr_en    = cs && write;
    assign edge_det = sync2_q ^ prev_q;
    assign tick     = (presc_q == PS_LAST);

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        presc_d = tick ? '0 : presc_q + PS_W'(1);
        en_d    = (wr_en && addr == 5'd5) ? wr_data[3:0] : en_q;
        clr     = (wr_en && addr == 5'd4) ? wr_data[3:0] : 4'b0;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            // clear first so a same-cycle capture below takes priority
            valid_d[i]  = valid_q[i] & ~clr[i];

            if (!en_q[i]) begin
                state_d[i] = DISARMED;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    DISARMED: begin
                        if (edge_det[i]) begin
                            cnt_d[i]   = '0;
                            state_d[i] = ARMED;
                        end
                    end
                    ARMED: begin
                        if (edge_det[i]) begin
                            period_d[i] = cnt_q[i];
                            valid_d[i]  = 1'b1;
                            cnt_d[i]    = '0;
                        end else if (tick && cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: state_d[i] = DISARMED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            presc_q <= '0;
            en_q    <= '0;
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i]  <= DISARMED;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            presc_q <= presc_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

    always_comb begin
        rd_data = 32'b0;
        case (addr)
            5'd0:    rd_data = 32'(period_q[0]);
            5'd1:    rd_data = 32'(period_q[1]);
            5'd2:    rd_data = 32'(period_q[2]);
            5'd3:    rd_data = 32'(period_q[3]);
            5'd4:    rd_data = {24'b0, sync2_q, valid_q};
            5'd5:    rd_data = {28'b0, en_q};
            default: rd_data = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: expected register reads are queued as stimulus is applied
// and compared when drained from the bus.
module tb_blink_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  din;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    int phase   = 0;

    typedef struct {
        string       tag;
        logic [4:0]  a;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #10 clk = ~clk;

    blink_meter #(.CLKS_PER_MS(10), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din)
    );

    // free cycle count, plus the ms-tick phase used to keep pin edges off tick cycles
    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        if (reset)           phase <= 0;
        else if (phase == 9) phase <= 0;
        else                 phase <= phase + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.a   = a;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x    = sb.pop_front();
            addr = x.a;
            read = 1'b1;
            #1;
            check(x.tag, rd_data, x.exp);
        end
        read = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = 32'b0;
    endtask

    task automatic wait_until(input int t);
        while (ncyc < t) @(negedge clk);
    endtask

    task automatic align();
        while (phase != 2) @(negedge clk);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int a = 0; a < 6; a++) expect_rd(tag, 5'(a), 32'h0);
    endtask

    int hp[4] = '{20, 30, 70, 100};
    int t0;

    initial begin
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'b0;
        din     = 4'b0;

        repeat (2) @(negedge clk);
        expect_all_zero("reset_regs");
        drain();
        reset = 1'b0;
        @(negedge clk);

        bus_wr(5'd5, 32'h1);
        expect_rd("en_write", 5'd5, 32'h1);
        drain();
        align();
        din[0] = 1'b1;
        t0 = ncyc;
        wait_until(t0 + 5);
        expect_rd("basic_first_period", 5'd0, 32'h0);
        expect_rd("basic_first_status", 5'd4, 32'h10);
        drain();
        wait_until(t0 + 50);
        din[0] = 1'b0;
        wait_until(t0 + 55);
        expect_rd("basic_period", 5'd0, 32'd5);
        expect_rd("basic_status", 5'd4, 32'h01);
        drain();

        bus_wr(5'd5, 32'hF);
        align();
        t0 = ncyc;
        for (int t = 0; t <= 210; t += 10) begin
            wait_until(t0 + t);
            for (int ch = 0; ch < 4; ch++)
                if (t % hp[ch] == 0) din[ch] = ~din[ch];
        end
        wait_until(t0 + 216);
        expect_rd("indep_p0", 5'd0, 32'd2);
        expect_rd("indep_p1", 5'd1, 32'd3);
        expect_rd("indep_p2", 5'd2, 32'd7);
        expect_rd("indep_p3", 5'd3, 32'd10);
        expect_rd("indep_status", 5'd4, {24'b0, din, 4'hF});
        expect_rd("indep_ctrl", 5'd5, 32'hF);
        expect_rd("unmapped_6", 5'd6, 32'h0);
        expect_rd("unmapped_31", 5'd31, 32'h0);
        drain();

        align();
        din[1] = ~din[1];
        t0 = ncyc;
        wait_until(t0 + 10);
        bus_wr(5'd4, 32'h2);
        expect_rd("sat_w1c_ch1", 5'd4, {24'b0, din, 4'hD});
        drain();
        wait_until(t0 + 300);
        din[1] = ~din[1];
        wait_until(t0 + 305);
        expect_rd("sat_period", 5'd1, 32'd15);
        expect_rd("sat_status", 5'd4, {24'b0, din, 4'hF});
        drain();

        bus_wr(5'd4, 32'h1);
        expect_rd("w1c_clear", 5'd4, {24'b0, din, 4'hE});
        drain();
        align();
        din[0] = ~din[0];
        t0 = ncyc;
        wait_until(t0 + 2);
        bus_wr(5'd4, 32'h1);
        wait_until(t0 + 6);
        expect_rd("w1c_race", 5'd4, {24'b0, din, 4'hF});
        drain();

        align();
        din[0] = ~din[0];
        t0 = ncyc;
        wait_until(t0 + 30);
        din[0] = ~din[0];
        wait_until(t0 + 35);
        expect_rd("dis_ref_period", 5'd0, 32'd3);
        drain();
        wait_until(t0 + 47);
        bus_wr(5'd5, 32'hE);
        wait_until(t0 + 70);
        din[0] = ~din[0];
        wait_until(t0 + 90);
        expect_rd("dis_retained", 5'd0, 32'd3);
        expect_rd("dis_ctrl", 5'd5, 32'hE);
        drain();
        bus_wr(5'd5, 32'hF);
        align();
        din[0] = ~din[0];
        t0 = ncyc;
        wait_until(t0 + 6);
        expect_rd("rearm_period", 5'd0, 32'd3);
        expect_rd("rearm_status", 5'd4, {24'b0, din, 4'hF});
        drain();

        align();
        din[2] = ~din[2];
        t0 = ncyc;
        wait_until(t0 + 25);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_all_zero("midrun_reset");
        drain();
        reset = 1'b0;
        repeat (6) @(negedge clk);
        bus_wr(5'd5, 32'h4);
        align();
        din[2] = ~din[2];
        t0 = ncyc;
        wait_until(t0 + 6);
        expect_rd("post_reset_status", 5'd4, {24'b0, din, 4'h0});
        expect_rd("post_reset_period", 5'd2, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
